// File: rtl/mmio_timer_pkg.sv
// Shared register map, CTRL/STATUS bit positions and reset constants for mmio_timer.
// TIMER_IRQ_EN selects whether CTRL.IRQEN is a writable bit.
package mmio_timer_pkg;

  localparam logic [4:0] OFF_CTRL     = 5'h00;
  localparam logic [4:0] OFF_PRESCALE = 5'h04;
  localparam logic [4:0] OFF_COUNT    = 5'h08;
  localparam logic [4:0] OFF_COMPARE  = 5'h0C;
  localparam logic [4:0] OFF_STATUS   = 5'h10;

  localparam int unsigned CTRL_EN         = 0;
  localparam int unsigned CTRL_AUTORELOAD = 1;
  localparam int unsigned CTRL_IRQEN      = 2;
  localparam int unsigned STATUS_MATCH    = 0;

  localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

`ifdef TIMER_IRQ_EN
  localparam logic [2:0] CTRL_WMASK = 3'b111;
`else
  localparam logic [2:0] CTRL_WMASK = 3'b011;
`endif

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler for mmio_timer: emits a one-cycle tick every (prescale + 1) enabled cycles.
module timer_prescaler #(
  parameter int unsigned PRESC_W = 16
) (
  input  logic               CLK,
  input  logic               RSTN,
  input  logic               enable_i,
  input  logic               clear_i,
  input  logic [PRESC_W-1:0] prescale_i,
  output logic               tick_o
);

  logic [PRESC_W-1:0] pcnt_q, pcnt_d;

  always_comb begin
    tick_o = enable_i && (pcnt_q == prescale_i);
    pcnt_d = pcnt_q;
    if (clear_i || !enable_i || tick_o) begin
      pcnt_d = '0;
    end else begin
      pcnt_d = pcnt_q + PRESC_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped prescaled timer with compare/match on the core data bus.
// Define TIMER_IRQ_EN to add the registered level IRQ output and CTRL.IRQEN.
module mmio_timer
  import mmio_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1001_1000,
  parameter int unsigned PRESC_W   = 16
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic [31:0] ADDR,
  input  logic [31:0] DATA_IN,
  output logic [31:0] DATA_OUT,
  input  logic        WR_EN,
  input  logic        RD_EN,
  output logic        HIT
`ifdef TIMER_IRQ_EN
  ,
  output logic        IRQ
`endif
);

  logic [2:0]         ctrl_q, ctrl_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [31:0]        count_q, count_d;
  logic [31:0]        compare_q, compare_d;
  logic               match_q, match_d;
  logic [4:0]         off;
  logic               hit, wr, tick, pclr, count_hit;
  logic [31:0]        rd_data;
  logic               unused_addr;

  // Byte lanes inside a word are not decoded.
  assign unused_addr = ^ADDR[1:0];
  assign off = {ADDR[4:2], 2'b00};
  assign hit = (ADDR[31:5] == BASE_ADDR[31:5]);
  assign wr  = WR_EN && hit;
  assign HIT = hit;

  assign pclr = wr && ((off == OFF_CTRL) || (off == OFF_PRESCALE));

  timer_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_prescaler (
    .CLK        (CLK),
    .RSTN       (RSTN),
    .enable_i   (ctrl_q[CTRL_EN]),
    .clear_i    (pclr),
    .prescale_i (presc_q),
    .tick_o     (tick)
  );

  always_comb begin
    ctrl_d    = ctrl_q;
    presc_d   = presc_q;
    compare_d = compare_q;
    count_d   = count_q;
    match_d   = match_q;
    count_hit = (count_q == compare_q);

    if (wr && (off == OFF_CTRL))     ctrl_d    = DATA_IN[2:0] & CTRL_WMASK;
    if (wr && (off == OFF_PRESCALE)) presc_d   = DATA_IN[PRESC_W-1:0];
    if (wr && (off == OFF_COMPARE))  compare_d = DATA_IN;

    // Bus write to COUNT takes priority over the tick update.
    if (wr && (off == OFF_COUNT)) begin
      count_d = DATA_IN;
    end else if (tick) begin
      count_d = (count_hit && ctrl_q[CTRL_AUTORELOAD]) ? '0 : count_q + 32'd1;
    end

    // A new match beats a simultaneous write-1-to-clear.
    if (tick && count_hit) begin
      match_d = 1'b1;
    end else if (wr && (off == OFF_STATUS) && DATA_IN[STATUS_MATCH]) begin
      match_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      ctrl_q    <= '0;
      presc_q   <= '0;
      count_q   <= '0;
      compare_q <= COMPARE_RST;
      match_q   <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      presc_q   <= presc_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      match_q   <= match_d;
    end
  end

`ifdef TIMER_IRQ_EN
  logic irq_q;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= match_d && ctrl_d[CTRL_IRQEN];
    end
  end

  assign IRQ = irq_q;
`endif

  always_comb begin
    rd_data = '0;
    case (off)
      OFF_CTRL:     rd_data = {29'd0, ctrl_q};
      OFF_PRESCALE: rd_data = 32'(presc_q);
      OFF_COUNT:    rd_data = count_q;
      OFF_COMPARE:  rd_data = compare_q;
      OFF_STATUS:   rd_data = {31'd0, match_q};
      default:      rd_data = '0;
    endcase
  end

  assign DATA_OUT = (RD_EN && hit) ? rd_data : '0;

endmodule

// File: tb/tb_mmio_timer.sv
// Directed self-checking bench for mmio_timer (both TIMER_IRQ_EN builds).
module tb_mmio_timer;

  localparam logic [31:0] BASE = 32'h1001_1000;
`ifdef TIMER_IRQ_EN
  localparam logic [31:0] CTRL_RUN_IRQ = 32'h5;
  localparam logic [31:0] CTRL_RD6     = 32'h6;
`else
  localparam logic [31:0] CTRL_RUN_IRQ = 32'h1;
  localparam logic [31:0] CTRL_RD6     = 32'h2;
`endif

  logic        CLK;
  logic        RSTN;
  logic [31:0] ADDR;
  logic [31:0] DATA_IN;
  logic [31:0] DATA_OUT;
  logic        WR_EN;
  logic        RD_EN;
  logic        HIT;
`ifdef TIMER_IRQ_EN
  logic        IRQ;
`endif

  int total = 0;
  int bad   = 0;

  mmio_timer #(
    .BASE_ADDR (BASE),
    .PRESC_W   (16)
  ) dut (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .ADDR     (ADDR),
    .DATA_IN  (DATA_IN),
    .DATA_OUT (DATA_OUT),
    .WR_EN    (WR_EN),
    .RD_EN    (RD_EN),
    .HIT      (HIT)
`ifdef TIMER_IRQ_EN
    ,
    .IRQ      (IRQ)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Write lands on the posedge inside this task; returns 1ns after it.
  task automatic wr_reg(input logic [31:0] off, input logic [31:0] data);
    @(negedge CLK);
    ADDR    = BASE + off;
    DATA_IN = data;
    WR_EN   = 1'b1;
    @(posedge CLK);
    #1;
    WR_EN   = 1'b0;
  endtask

  task automatic rd_reg(input logic [31:0] off, output logic [31:0] data);
    ADDR  = BASE + off;
    RD_EN = 1'b1;
    #1;
    data  = DATA_OUT;
    RD_EN = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    wr_reg(32'h04, 32'd1);
    wr_reg(32'h0C, 32'd3);
    wr_reg(32'h00, CTRL_RUN_IRQ);
    repeat (10) @(posedge CLK);
    #3;
    RSTN = 1'b0;
    #1;
    rd_reg(32'h00, d); total++;
    if (d !== 32'h0) begin bad++; $display("FAIL reset_ctrl got=%h exp=%h", d, 32'h0); end
    rd_reg(32'h04, d); total++;
    if (d !== 32'h0) begin bad++; $display("FAIL reset_presc got=%h exp=%h", d, 32'h0); end
    rd_reg(32'h08, d); total++;
    if (d !== 32'h0) begin bad++; $display("FAIL reset_count got=%h exp=%h", d, 32'h0); end
    rd_reg(32'h0C, d); total++;
    if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL reset_compare got=%h exp=ffffffff", d); end
    rd_reg(32'h10, d); total++;
    if (d !== 32'h0) begin bad++; $display("FAIL reset_status got=%h exp=%h", d, 32'h0); end
`ifdef TIMER_IRQ_EN
    total++;
    if (IRQ !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", IRQ); end
`endif
    @(negedge CLK);
    RSTN = 1'b1;
  endtask

  task automatic test_decode();
    logic [31:0] d;
    rd_reg(32'h20, d); total++;
    if (HIT !== 1'b0 || d !== 32'h0) begin
      bad++; $display("FAIL decode_miss hit=%b data=%h exp hit=0 data=0", HIT, d);
    end
    rd_reg(32'h14, d); total++;
    if (HIT !== 1'b1 || d !== 32'h0) begin
      bad++; $display("FAIL decode_reserved hit=%b data=%h exp hit=1 data=0", HIT, d);
    end
    wr_reg(32'h0B, 32'h1234_5678);
    rd_reg(32'h08, d); total++;
    if (d !== 32'h1234_5678) begin bad++; $display("FAIL decode_misaligned got=%h exp=12345678", d); end
    ADDR = BASE + 32'h08; RD_EN = 1'b0; #1; total++;
    if (DATA_OUT !== 32'h0) begin bad++; $display("FAIL decode_rd_low got=%h exp=0", DATA_OUT); end
    // Simultaneous read/write returns the old value, new value after the edge.
    wr_reg(32'h0C, 32'hAAAA_0001);
    @(negedge CLK);
    ADDR = BASE + 32'h0C; DATA_IN = 32'h5555_0002; WR_EN = 1'b1; RD_EN = 1'b1;
    #1; total++;
    if (DATA_OUT !== 32'hAAAA_0001) begin bad++; $display("FAIL rdwr_old got=%h exp=aaaa0001", DATA_OUT); end
    @(posedge CLK); #1;
    WR_EN = 1'b0; RD_EN = 1'b0;
    rd_reg(32'h0C, d); total++;
    if (d !== 32'h5555_0002) begin bad++; $display("FAIL rdwr_new got=%h exp=55550002", d); end
    wr_reg(32'h00, 32'h6);
    rd_reg(32'h00, d); total++;
    if (d !== CTRL_RD6) begin bad++; $display("FAIL ctrl_irqen_bit got=%h exp=%h", d, CTRL_RD6); end
    wr_reg(32'h00, 32'h0);
  endtask

  task automatic test_prescale();
    logic [31:0] d;
    wr_reg(32'h08, 32'd0);
    wr_reg(32'h04, 32'd3);
    wr_reg(32'h00, 32'd1);
    rd_reg(32'h08, d); total++;
    if (d !== 32'd0) begin bad++; $display("FAIL presc_k got=%h exp=0", d); end
    for (int j = 1; j <= 12; j++) begin
      @(posedge CLK); #1;
      if (j == 3 || j % 4 == 0) begin
        rd_reg(32'h08, d); total++;
        if (d !== 32'(j / 4)) begin
          bad++; $display("FAIL presc_k+%0d got=%h exp=%h", j, d, 32'(j / 4));
        end
      end
    end
    wr_reg(32'h00, 32'd0);
  endtask

  task automatic test_autoreload();
    logic [31:0] d;
    logic [31:0] exp_cnt [7] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd0, 32'd1};
    wr_reg(32'h08, 32'd0);
    wr_reg(32'h10, 32'd1);
    wr_reg(32'h04, 32'd0);
    wr_reg(32'h0C, 32'd5);
    wr_reg(32'h00, 32'h3);
    for (int j = 0; j < 7; j++) begin
      @(posedge CLK); #1;
      rd_reg(32'h08, d); total++;
      if (d !== exp_cnt[j]) begin bad++; $display("FAIL autoreload_cnt%0d got=%h exp=%h", j, d, exp_cnt[j]); end
      rd_reg(32'h10, d); total++;
      if (d !== ((j >= 5) ? 32'd1 : 32'd0)) begin
        bad++; $display("FAIL autoreload_match%0d got=%h exp=%h", j, d, (j >= 5) ? 32'd1 : 32'd0);
      end
    end
    wr_reg(32'h10, 32'd1);
    rd_reg(32'h10, d); total++;
    if (d !== 32'd0) begin bad++; $display("FAIL w1c_clear got=%h exp=0", d); end
    wr_reg(32'h00, 32'd0);
  endtask

  task automatic test_noreload();
    logic [31:0] d;
    wr_reg(32'h08, 32'd0);
    wr_reg(32'h10, 32'd1);
    wr_reg(32'h0C, 32'd2);
    wr_reg(32'h00, 32'd1);
    for (int j = 1; j <= 4; j++) begin
      @(posedge CLK); #1;
      rd_reg(32'h08, d); total++;
      if (d !== 32'(j)) begin bad++; $display("FAIL noreload_cnt%0d got=%h exp=%h", j, d, 32'(j)); end
    end
    rd_reg(32'h10, d); total++;
    if (d !== 32'd1) begin bad++; $display("FAIL noreload_match got=%h exp=1", d); end
    wr_reg(32'h10, 32'd1);
    wr_reg(32'h08, 32'hFFFF_FFFE);
    rd_reg(32'h08, d); total++;
    if (d !== 32'hFFFF_FFFE) begin bad++; $display("FAIL wrap_set got=%h exp=fffffffe", d); end
    @(posedge CLK); #1;
    rd_reg(32'h08, d); total++;
    if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_max got=%h exp=ffffffff", d); end
    @(posedge CLK); #1;
    rd_reg(32'h08, d); total++;
    if (d !== 32'h0) begin bad++; $display("FAIL wrap_zero got=%h exp=0", d); end
    rd_reg(32'h10, d); total++;
    if (d !== 32'h0) begin bad++; $display("FAIL wrap_noflag got=%h exp=0", d); end
    wr_reg(32'h00, 32'd0);
  endtask

  task automatic test_collisions();
    logic [31:0] d;
    wr_reg(32'h0C, 32'hFFFF_FFFF);
    wr_reg(32'h08, 32'd40);
    wr_reg(32'h00, 32'd1);
    @(posedge CLK); #1;
    wr_reg(32'h08, 32'd100);
    rd_reg(32'h08, d); total++;
    if (d !== 32'd100) begin bad++; $display("FAIL count_write_wins got=%0d exp=100", d); end
    @(posedge CLK); #1;
    rd_reg(32'h08, d); total++;
    if (d !== 32'd101) begin bad++; $display("FAIL count_after_write got=%0d exp=101", d); end
    wr_reg(32'h00, 32'd0);
    wr_reg(32'h0C, 32'd10);
    wr_reg(32'h08, 32'd8);
    wr_reg(32'h10, 32'd1);
    wr_reg(32'h00, CTRL_RUN_IRQ);
    @(posedge CLK);
    @(posedge CLK); #1;
`ifdef TIMER_IRQ_EN
    total++;
    if (IRQ !== 1'b0) begin bad++; $display("FAIL irq_before got=%b exp=0", IRQ); end
`endif
    wr_reg(32'h10, 32'd1);
    rd_reg(32'h10, d); total++;
    if (d !== 32'd1) begin bad++; $display("FAIL match_beats_w1c got=%h exp=1", d); end
`ifdef TIMER_IRQ_EN
    total++;
    if (IRQ !== 1'b1) begin bad++; $display("FAIL irq_beats_w1c got=%b exp=1", IRQ); end
`endif
    wr_reg(32'h00, 32'd0);
  endtask

  initial begin
    RSTN = 1'b0; ADDR = '0; DATA_IN = '0; WR_EN = 1'b0; RD_EN = 1'b0;
    #12;
    RSTN = 1'b1;
    test_reset();
    test_decode();
    test_prescale();
    test_autoreload();
    test_noreload();
    test_collisions();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmio_timer.md
# mmio_timer

Memory-mapped timer that responds to the RISC_V core's data-memory bus, the responder side of the core's load/store interface, alongside DATA_MEM. It decodes a 32-byte window of the data address space and provides a prescaled 32-bit up-counter, a compare register and a sticky match flag. With the IRQ option compiled in, it also drives a level interrupt. Write and read strobes use the same semantics as DATA_MEM, so the testbench or system top can place it on the core's data bus with a simple read-data mux.

## Interface
- BASE_ADDR, 32'h1001_1000: byte address of the register window; bits [4:0] must be zero.
- PRESC_W, 16: width of the PRESCALE register and the prescaler counter.
- CLK  in  1  system clock; all state updates on the rising edge.
- RSTN  in  1  reset; one clock, reset is asynchronous and active-low.
- ADDR  in  32  byte address from the core (DATA_ADDR).
- DATA_IN  in  32  write data from the core.
- DATA_OUT  out  32  read data to the core.
- WR_EN  in  1  store strobe.
- RD_EN  in  1  load strobe.
- HIT  out  1  high when ADDR[31:5] == BASE_ADDR[31:5]; the system top uses it to select DATA_OUT over DATA_MEM.
- IRQ  out  1  level interrupt; present only with TIMER_IRQ_EN.

## Operation
- Register map (offset = ADDR[4:0]; ADDR[1:0] ignored):
  - 0x00 CTRL: bit0 EN, bit1 AUTORELOAD, bit2 IRQEN; other bits read 0.
  - 0x04 PRESCALE: low PRESC_W bits.
  - 0x08 COUNT: 32-bit counter.
  - 0x0C COMPARE.
  - 0x10 STATUS: bit0 MATCH, write-1-to-clear.
  - Offsets 0x14–0x1C: read 0, writes ignored.
- Write: takes effect at the CLK edge when WR_EN && HIT.
- Read: combinational. DATA_OUT = selected register when RD_EN && HIT, otherwise 0.
- WR_EN and RD_EN both high: the write is performed, and the read returns the pre-write value.
- Prescaler, running only while EN = 1:
  - pcnt counts 0..PRESCALE; on pcnt == PRESCALE it emits tick and returns to 0.
  - PRESCALE = 0 gives a tick every cycle.
- On tick:
  - COUNT == COMPARE: MATCH is set; COUNT becomes 0 if AUTORELOAD = 1, otherwise COUNT + 1.
  - Otherwise COUNT becomes COUNT + 1 (modulo 2^32; 0xFFFF_FFFF wraps to 0 with no flag).
- EN = 0: pcnt is held at 0 and COUNT is frozen.
- Any write to PRESCALE or CTRL clears pcnt.
- Simultaneous events:
  - A core write to COUNT wins over a tick increment in the same cycle.
  - A MATCH set wins over a W1C clear in the same cycle.
  - A write to COMPARE uses the new value from the next cycle onward.

## Timing
- Reset values: CTRL = 0, PRESCALE = 0, COUNT = 0, COMPARE = 32'hFFFF_FFFF, MATCH = 0, pcnt = 0, IRQ = 0. HIT and DATA_OUT follow their inputs combinationally (DATA_OUT = 0 while RD_EN = 0).
- Zero read latency: same-cycle data, as DATA_MEM.
- Write visibility: a register written at edge k is read back from cycle k onward.
- Enable latency: EN written at edge k with PRESCALE = P gives the first COUNT increment at edge k + P + 1.
- MATCH is visible in the cycle after the tick edge on which COUNT == COMPARE.
- Reset asserted mid-count returns every register to its reset value asynchronously. No partial state survives.

## Configuration
- TIMER_IRQ_EN defined: IRQ port exists, registered, IRQ = MATCH && IRQEN, updated with MATCH; CTRL bit2 is read/write.
- TIMER_IRQ_EN undefined: IRQ port absent, CTRL bit2 reads 0, writes to it are ignored.

## Structure
- Package mmio_timer_pkg holds:
  - register offset localparams (OFF_CTRL, OFF_PRESCALE, OFF_COUNT, OFF_COMPARE, OFF_STATUS);
  - CTRL bit indices (CTRL_EN, CTRL_AUTORELOAD, CTRL_IRQEN) and STATUS_MATCH;
  - COMPARE reset constant.
- One sub-module, timer_prescaler:
  - inputs: CLK, RSTN, enable, clear, PRESCALE;
  - output: one-cycle tick pulse.
- Top-level mmio_timer contains the address decode, the register file and the COUNT/MATCH logic.

## Test plan
- Reset: assert RSTN low mid-count, then read all 5 offsets. Expect CTRL = 0, PRESCALE = 0, COUNT = 0, COMPARE = FFFF_FFFF, STATUS = 0, IRQ = 0.
- Decode:
  - Read at BASE_ADDR + 0x20 → HIT = 0, DATA_OUT = 0.
  - Read at BASE_ADDR + 0x14 → HIT = 1, DATA_OUT = 0.
  - Write at BASE_ADDR + 0x0B (misaligned) → lands in COUNT.
- Prescale: PRESCALE = 3, CTRL = 1 written at edge k. Expect COUNT = 1 at k + 4, COUNT = 2 at k + 8, COUNT = 3 at k + 12.
- Compare with AUTORELOAD = 1: PRESCALE = 0, COMPARE = 5, CTRL = 0x3.
  - COUNT sequence 1,2,3,4,5,0,1.
  - MATCH = 1 after the tick at COUNT = 5.
  - Write STATUS = 1 → MATCH = 0.
- Compare without AUTORELOAD: CTRL = 1, COMPARE = 2. COUNT continues 3,4 after the match. Then set COUNT = FFFF_FFFE → reads FFFF_FFFF then 0.
- Collisions:
  - Write COUNT = 100 on a tick edge → COUNT reads 100, not an increment.
  - W1C STATUS on the same edge as a new match → MATCH stays 1; with TIMER_IRQ_EN and IRQEN = 1, IRQ stays 1.
